sqrt_stream_adapter: RTL

Streaming front/back-end for the iterative square-root core.
- Accepts operands on a valid/ready input stream and buffers them in a 2-entry FIFO.
- Launches the core one operand at a time and waits for its completion pulse.
- Presents each root, with an error flag and cycle count, on a valid/ready output stream.
- Guards every launch with a timeout and clears the core if it hangs.

---
 rtl/sqrt_pkg.sv | 16 +
 rtl/sqrt_in_fifo.sv | 51 +++++
 rtl/sqrt_stream_adapter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/sqrt_pkg.sv
// Shared definitions for the square-root stream adapter: FSM encoding,
// default widths and the bypass threshold for trivial operands.
package sqrt_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        RUN   = 2'b11,
        CLEAR = 2'b10
    } state_e;

    localparam int DEFAULT_DATA_W  = 16;
    localparam int DEFAULT_TIMEOUT = 40;
    localparam int BYPASS_LIMIT    = 2;

endpackage

// File: rtl/sqrt_in_fifo.sv
// Two-entry operand FIFO. The caller only pushes when count_o < 2 and only
// pops when count_o > 0; the head is always the oldest entry.
module sqrt_in_fifo
    import sqrt_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] head_o,
    output logic [1:0]        count_o
);

    logic [DATA_W-1:0] mem_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        count_q;

    // NOTE: the storage array is deliberately not reset; count_q alone decides
    // whether an entry is live, so stale data can never be observed.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) wr_ptr_q <= ~wr_ptr_q;
            if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/sqrt_stream_adapter.sv
// Valid/ready wrapper around the iterative square-root core: buffers operands,
// launches the core one at a time, times out hung runs and streams results.
module sqrt_stream_adapter
    import sqrt_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int ROOT_W  = DATA_W / 2,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              core_start_o,
    output logic [DATA_W-1:0] core_operand_o,
    output logic              core_clr_o,
    input  logic              core_done_i,
    input  logic [ROOT_W-1:0] core_root_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [ROOT_W-1:0] out_root_o,
    output logic              out_err_o,
    output logic [CNT_W-1:0]  out_cycles_o
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] operand_q, operand_d;
    logic              start_q, start_d;
    logic              clr_q, clr_d;
    logic              out_valid_q, out_valid_d;
    logic [ROOT_W-1:0] out_root_q, out_root_d;
    logic              out_err_q, out_err_d;
    logic [CNT_W-1:0]  out_cycles_q, out_cycles_d;

    logic              push, pop;
    logic [DATA_W-1:0] head;
    logic [1:0]        count;
    logic              slot_free;

    assign in_ready_o = (count != 2'd2);
    assign push       = in_valid_i & in_ready_o;
    assign slot_free  = ~out_valid_q | out_ready_i;

    sqrt_in_fifo #(.DATA_W(DATA_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (in_data_i),
        .head_o  (head),
        .count_o (count)
    );

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        operand_d    = operand_q;
        start_d      = 1'b0;
        clr_d        = 1'b0;
        pop          = 1'b0;
        out_valid_d  = out_valid_q & ~out_ready_i;
        out_root_d   = out_root_q;
        out_err_d    = out_err_q;
        out_cycles_d = out_cycles_q;

        case (state_q)
            IDLE: begin
                if (count != 2'd0 && slot_free) begin
                    pop = 1'b1;
                    // Roots of 0 and 1 are the operands themselves.
                    if (head < DATA_W'(BYPASS_LIMIT)) begin
                        out_valid_d  = 1'b1;
                        out_root_d   = {{(ROOT_W-1){1'b0}}, head[0]};
                        out_err_d    = 1'b0;
                        out_cycles_d = '0;
                    end else begin
                        operand_d = head;
                        start_d   = 1'b1;
                        state_d   = START;
                    end
                end
            end
            START: begin
                cnt_d   = CNT_W'(1);
                state_d = RUN;
            end
            RUN: begin
                if (core_done_i) begin
                    out_valid_d  = 1'b1;
                    out_root_d   = core_root_i;
                    out_err_d    = 1'b0;
                    out_cycles_d = cnt_q;
                    state_d      = IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    out_valid_d  = 1'b1;
                    out_root_d   = '0;
                    out_err_d    = 1'b1;
                    out_cycles_d = CNT_W'(TIMEOUT);
                    clr_d        = 1'b1;
                    state_d      = CLEAR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CLEAR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            operand_q    <= '0;
            start_q      <= 1'b0;
            clr_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            out_root_q   <= '0;
            out_err_q    <= 1'b0;
            out_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            operand_q    <= operand_d;
            start_q      <= start_d;
            clr_q        <= clr_d;
            out_valid_q  <= out_valid_d;
            out_root_q   <= out_root_d;
            out_err_q    <= out_err_d;
            out_cycles_q <= out_cycles_d;
        end
    end

    assign core_start_o   = start_q;
    assign core_operand_o = operand_q;
    assign core_clr_o     = clr_q;
    assign out_valid_o    = out_valid_q;
    assign out_root_o     = out_root_q;
    assign out_err_o      = out_err_q;
    assign out_cycles_o   = out_cycles_q;

endmodule
